// File: rtl/seq_muldiv_pkg.sv
// muldiv_pkg: shared op, state and flag types for seq_muldiv
package muldiv_pkg;
    typedef enum logic {MD_MUL, MD_DIV} muldiv_op_t;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;
    typedef struct packed {
        logic div_by_zero;
        logic overflow;
    } muldiv_flags_t;
endpackage

// File: rtl/cond_negate.sv
// cond_negate: two's-complement negate when neg is set
module cond_negate #(
    parameter int WIDTH = 16
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);
    assign result = neg ? -value : value;
endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative signed/unsigned mul/div; define SEQ_MULDIV_EARLY_EXIT_EN for variable-latency MUL
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic             overflow
);
    muldiv_state_t        state;
    muldiv_op_t           op_r;
    muldiv_flags_t        flags;
    logic                 sign_q, sign_r, dbz_r, ovf_r, sa, sb, done_iter;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc, ma, mul_next, prod_fix;
    logic [WIDTH-1:0]     mb, mag_a, mag_b, rem_sh, rem_fix, quot_fix;
    logic [WIDTH:0]       trial;

    assign sa          = is_signed & a[WIDTH-1];
    assign sb          = is_signed & b[WIDTH-1];
    assign in_ready    = state == IDLE;
    assign div_by_zero = flags.div_by_zero;
    assign overflow    = flags.overflow;
    assign mul_next    = acc + (mb[0] ? ma : '0);
    // DIV keeps {remainder, dividend} in acc and shifts one dividend bit into the remainder per step
    assign rem_sh      = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    assign trial       = {1'b0, rem_sh} - {1'b0, ma[WIDTH-1:0]};
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
    assign done_iter = count == CNT_W'(WIDTH - 1) || (op_r == MD_MUL && mb[WIDTH-1:1] == '0);
`else
    assign done_iter = count == CNT_W'(WIDTH - 1);
`endif

    cond_negate #(.WIDTH(WIDTH))   u_neg_a (.neg(sa),     .value(a),                   .result(mag_a));
    cond_negate #(.WIDTH(WIDTH))   u_neg_b (.neg(sb),     .value(b),                   .result(mag_b));
    cond_negate #(.WIDTH(2*WIDTH)) u_neg_p (.neg(sign_q), .value(acc),                 .result(prod_fix));
    cond_negate #(.WIDTH(WIDTH))   u_neg_q (.neg(sign_q), .value(acc[WIDTH-1:0]),      .result(quot_fix));
    cond_negate #(.WIDTH(WIDTH))   u_neg_r (.neg(sign_r), .value(acc[2*WIDTH-1:WIDTH]), .result(rem_fix));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= MD_MUL;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dbz_r     <= 1'b0;
            ovf_r     <= 1'b0;
            count     <= '0;
            acc       <= '0;
            ma        <= '0;
            mb        <= '0;
            out_valid <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r   <= op;
                    sign_q <= sa ^ sb;
                    sign_r <= sa;
                    dbz_r  <= op == MD_DIV && b == '0;
                    ovf_r  <= is_signed && op == MD_DIV && a == {1'b1, {(WIDTH-1){1'b0}}} && &b;
                    count  <= '0;
                    acc    <= op == MD_MUL ? '0 : {{WIDTH{1'b0}}, b == '0 ? a : mag_a};
                    ma     <= {{WIDTH{1'b0}}, op == MD_MUL ? mag_a : mag_b};
                    mb     <= mag_b;
                    state  <= op == MD_DIV && b == '0 ? FIX : CALC;
                end
                CALC: begin
                    count <= count + 1'b1;
                    ma    <= op_r == MD_MUL ? ma << 1 : ma;
                    mb    <= mb >> 1;
                    acc   <= op_r == MD_MUL ? mul_next :
                             trial[WIDTH] ? {rem_sh, acc[WIDTH-2:0], 1'b0} :
                                            {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    state <= done_iter ? FIX : CALC;
                end
                FIX: begin
                    result_hi <= dbz_r ? acc[WIDTH-1:0] : op_r == MD_MUL ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
                    result_lo <= dbz_r ? '1 : op_r == MD_MUL ? prod_fix[WIDTH-1:0] : quot_fix;
                    flags     <= '{div_by_zero: dbz_r, overflow: ovf_r};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: randomized scoreboard bench for seq_muldiv against an arithmetic reference model
module tb_seq_muldiv;
    import muldiv_pkg::*;
    localparam int W = 16;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, is_signed = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, div_by_zero, overflow;
    muldiv_op_t op = MD_MUL;
    logic [W-1:0] a = '0, b = '0, result_hi, result_lo;

    typedef struct {
        logic [W-1:0] hi, lo;
        logic         dbz, ovf;
        int           lat, acc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0, bad = 0, cyc = 0, last_hs = -100;
    logic busy = 1'b0, bp5 = 1'b0;

    seq_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .is_signed(is_signed), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst)
        if (rst) busy <= 1'b0;
        else     busy <= busy ? !(out_valid && out_ready) : in_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit div, input bit s, input logic [W-1:0] ia, input logic [W-1:0] ib);
        exp_t        e;
        longint      va, vb;
        logic [63:0] p;
        va = s ? longint'($signed(ia)) : longint'(ia);
        vb = s ? longint'($signed(ib)) : longint'(ib);
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.lat = W + 1;
        e.acc = 0;
        if (!div) begin
            p = va * vb;
            {e.hi, e.lo} = p[2*W-1:0];
`ifdef SEQ_MULDIV_EARLY_EXIT_EN
            begin
                longint mag;
                int     n;
                mag = vb < 0 ? -vb : vb;
                n = 1;
                for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
                e.lat = n + 1;
            end
`endif
        end else if (ib == '0) begin
            e.hi  = ia;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            p = va / vb;
            e.lo = p[W-1:0];
            p = va % vb;
            e.hi = p[W-1:0];
            e.ovf = s && va == -(64'sd1 <<< (W - 1)) && vb == -1;
        end
        return e;
    endfunction

    task automatic issue(input bit div, input bit s, input logic [W-1:0] ia, input logic [W-1:0] ib, output int acc);
        exp_t e;
        int   n = 0;
        op        = div ? MD_DIV : MD_MUL;
        is_signed = s;
        a         = ia;
        b         = ib;
        in_valid  = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready still %0b after %0d cycles", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        e = model(div, s, ia, ib);
        e.acc = acc;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = muldiv_op_t'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: %0d results still pending", sbq.size());
        end
    endtask

    initial begin : monitor
        logic         seen = 1'b0;
        int           hold = 0;
        logic [W-1:0] chi, clo;
        logic         cdbz, covf;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                out_ready = 1'b0;
            end else begin
                check("in_ready", in_ready, !busy);
                if (out_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        {chi, clo, cdbz, covf} = {result_hi, result_lo, div_by_zero, overflow};
                        if (sbq.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_result: hi=%0h lo=%0h with empty scoreboard", result_hi, result_lo);
                        end else begin
                            e = sbq.pop_front();
                            check("result_hi", result_hi, e.hi);
                            check("result_lo", result_lo, e.lo);
                            check("div_by_zero", div_by_zero, e.dbz);
                            check("overflow", overflow, e.ovf);
                            check("latency", cyc - e.acc, e.lat);
                        end
                        hold = bp5 ? 5 : $urandom_range(0, 2);
                    end else begin
                        check("hold_stable", {result_hi, result_lo, div_by_zero, overflow}, {chi, clo, cdbz, covf});
                    end
                    out_ready = hold == 0;
                    if (hold > 0) hold--;
                    if (out_ready) last_hs = cyc + 1;
                end else begin
                    seen = 1'b0;
                    out_ready = 1'b0;
                end
            end
        end
    end

    initial begin : driver
        int acc, acc2;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check("reset_results", {result_hi, result_lo}, 0);
        check("reset_flags", {div_by_zero, overflow}, 0);
        check("reset_out_valid", out_valid, 0);

        issue(0, 0, 16'hFFFF, 16'hFFFF, acc);
        issue(0, 1, 16'hFFFD, 16'h0007, acc);
        issue(0, 0, 16'hFFFD, 16'h0007, acc);
        issue(1, 0, 16'd100, 16'd7, acc);
        issue(1, 1, 16'hFFF9, 16'h0002, acc);
        issue(1, 0, 16'h1234, 16'h0000, acc);
        issue(1, 1, 16'h8000, 16'hFFFF, acc);
        issue(1, 0, 16'h8000, 16'hFFFF, acc);
        issue(0, 1, 16'h8000, 16'h8000, acc);
        wait_idle();

        bp5 = 1'b1;
        issue(0, 0, 16'h1234, 16'h5678, acc);
        issue(1, 1, 16'h8765, 16'h0013, acc2);
        bp5 = 1'b0;
        check("accept_after_handshake", acc2, last_hs + 1);
        wait_idle();

        issue(0, 0, 16'hABCD, 16'h1357, acc);
        while (cyc < acc + 8) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_results", {result_hi, result_lo, div_by_zero, overflow}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        repeat (20) @(negedge clk);
        check("abort_no_result", out_valid, 0);

        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] ra, rb;
            int           sel;
            sel = $urandom_range(0, 7);
            ra  = $urandom_range(0, 7) == 0 ? 16'h8000 : W'($urandom);
            rb  = sel == 0 ? '0 : sel == 1 ? '1 : sel == 2 ? W'($urandom_range(0, 15)) : W'($urandom);
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb, acc);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
